// File: rtl/display_frame_controller.sv
// display_frame_controller
//   Sequences what the graphics pixel datapath renders. Owns the displayed
//   screen select, the T-spin banner flag and the test-pattern enable, and
//   only changes them on frame boundaries. Every screen change inserts
//   BLANK_FRAMES whole frames of background-only output.
//
// Optional feature (macro TSPIN_BLINK_EN):
//   defined   -> T-spin banner blinks 8 frames on / 8 frames off while lit
//   undefined -> T-spin banner is solid while lit
//
// Ports
//   clk                 system clock
//   rst_l               asynchronous active-low reset
//   frame_start         one-cycle pulse at start of vertical blank
//   screen_req          screen requested by game logic
//   tspin_event         one-cycle pulse, T-spin detected
//   testpattern_req     asynchronous test-pattern switch
//   display_screen      screen select to graphics mux
//   display_tspin       T-spin banner enable
//   display_testpattern test-pattern enable
//   blank_active        graphics shows background only
//   screen_changed      one-cycle pulse on screen commit

package display_frame_pkg;
  typedef enum logic [2:0] {
    START_SCREEN = 3'd0,
    SPRINT_MODE  = 3'd1,
    MP_READY     = 3'd2,
    MP_GAME      = 3'd3,
    GAME_OVER    = 3'd4
  } game_screens_t;
endpackage

module display_frame_controller
  import display_frame_pkg::*;
#(
  parameter int BLANK_FRAMES      = 4,
  parameter int TSPIN_HOLD_FRAMES = 60,
  parameter int CNT_W             = 8
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          frame_start,
  input  game_screens_t screen_req,
  input  logic          tspin_event,
  input  logic          testpattern_req,
  output game_screens_t display_screen,
  output logic          display_tspin,
  output logic          display_testpattern,
  output logic          blank_active,
  output logic          screen_changed
);

  typedef enum logic [1:0] {SHOW, WAIT_FRAME, BLANK} state_t;

  localparam logic             L_NO_BLANK = (BLANK_FRAMES == 0);
  localparam logic [CNT_W-1:0] L_BLANK_N  = CNT_W'(BLANK_FRAMES);
  localparam logic [CNT_W-1:0] L_HOLD_N   = CNT_W'(TSPIN_HOLD_FRAMES);

  state_t           r_state;
  game_screens_t    r_pending;
  logic [CNT_W-1:0] r_blank_cnt;
  logic [CNT_W-1:0] r_tspin_cnt;
  logic             r_tp_meta;
  logic             r_tp_sync;

  logic             w_commit;
  logic [CNT_W-1:0] w_tspin_nxt;
  logic             w_tspin_on;

  // Commit happens on a frame boundary: straight from WAIT_FRAME when no
  // blanking is configured, or on the last frame of the blank period.
  // A withdrawn request in WAIT_FRAME never commits.
  always_comb begin
    w_commit = 1'b0;
    if (frame_start) begin
      if (r_state == WAIT_FRAME && screen_req != display_screen && L_NO_BLANK)
        w_commit = 1'b1;
      if (r_state == BLANK && r_blank_cnt <= 1)
        w_commit = 1'b1;
    end
  end

  // Priority: commit clear > event reload > frame decrement.
  always_comb begin
    w_tspin_nxt = r_tspin_cnt;
    if (w_commit)
      w_tspin_nxt = '0;
    else if (tspin_event && r_state == SHOW)
      w_tspin_nxt = L_HOLD_N;
    else if (frame_start && r_tspin_cnt != '0)
      w_tspin_nxt = r_tspin_cnt - 1'b1;
  end

`ifdef TSPIN_BLINK_EN
  logic [CNT_W-1:0] r_blink_cnt;
  logic [CNT_W-1:0] w_blink_nxt;

  // Reloading to 8 puts bit 3 high so the banner lights on the event itself.
  always_comb begin
    w_blink_nxt = r_blink_cnt;
    if (tspin_event)
      w_blink_nxt = CNT_W'(8);
    else if (frame_start)
      w_blink_nxt = r_blink_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) r_blink_cnt <= '0;
    else        r_blink_cnt <= w_blink_nxt;
  end

  assign w_tspin_on = (w_tspin_nxt != '0) && w_blink_nxt[3];
`else
  assign w_tspin_on = (w_tspin_nxt != '0);
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state             <= SHOW;
      r_pending           <= START_SCREEN;
      r_blank_cnt         <= '0;
      r_tspin_cnt         <= '0;
      r_tp_meta           <= 1'b0;
      r_tp_sync           <= 1'b0;
      display_screen      <= START_SCREEN;
      display_tspin       <= 1'b0;
      display_testpattern <= 1'b0;
      blank_active        <= 1'b0;
      screen_changed      <= 1'b0;
    end else begin
      screen_changed <= 1'b0;

      // Test pattern path is independent of the screen FSM.
      r_tp_meta <= testpattern_req;
      r_tp_sync <= r_tp_meta;
      if (frame_start) display_testpattern <= r_tp_sync;

      r_tspin_cnt   <= w_tspin_nxt;
      display_tspin <= w_tspin_on;

      case (r_state)
        SHOW: begin
          if (screen_req != display_screen) begin
            r_pending <= screen_req;
            r_state   <= WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (screen_req == display_screen) begin
            r_state <= SHOW;
          end else begin
            r_pending <= screen_req;
            if (frame_start && !L_NO_BLANK) begin
              blank_active <= 1'b1;
              r_blank_cnt  <= L_BLANK_N;
              r_state      <= BLANK;
            end
          end
        end
        BLANK: begin
          // Latest request wins; the blank period itself is never restarted.
          r_pending <= screen_req;
          if (frame_start && r_blank_cnt > 1)
            r_blank_cnt <= r_blank_cnt - 1'b1;
        end
        default: r_state <= SHOW;
      endcase

      // Commits the registered pending screen, even if it equals the old one.
      if (w_commit) begin
        display_screen <= r_pending;
        blank_active   <= 1'b0;
        screen_changed <= 1'b1;
        r_blank_cnt    <= '0;
        r_state        <= SHOW;
      end
    end
  end

endmodule

// File: tb/tb_display_frame_controller.sv
module tb_display_frame_controller;
  import display_frame_pkg::*;

  localparam int BF   = 4;
  localparam int HOLD = 60;
  localparam int FL   = 4;   // cycles per frame in directed tests

  logic          clk;
  logic          rst_l;
  logic          d_fs, d_ev, d_tp;
  game_screens_t d_req;
  game_screens_t display_screen;
  logic          display_tspin, display_testpattern, blank_active, screen_changed;

  int checks = 0;
  int errors = 0;

  display_frame_controller #(.BLANK_FRAMES(BF), .TSPIN_HOLD_FRAMES(HOLD), .CNT_W(8)) dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .frame_start         (d_fs),
    .screen_req          (d_req),
    .tspin_event         (d_ev),
    .testpattern_req     (d_tp),
    .display_screen      (display_screen),
    .display_tspin       (display_tspin),
    .display_testpattern (display_testpattern),
    .blank_active        (blank_active),
    .screen_changed      (screen_changed)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference model: a screen request is "wanted" once it differs from the
  // shown screen; blanking counts whole frames; banner counts frames left.
  logic [2:0] m_cur, m_pend;
  bit         m_wanted, m_blanking;
  int         m_frames_left, m_tsp_left, m_blink;
  bit         m_chg, m_tp, m_s1, m_s2;

  task automatic m_reset();
    m_cur = 3'd0; m_pend = 3'd0; m_wanted = 0; m_blanking = 0;
    m_frames_left = 0; m_tsp_left = 0; m_blink = 0;
    m_chg = 0; m_tp = 0; m_s1 = 0; m_s2 = 0;
  endtask

  task automatic m_step();
    bit idle = !m_wanted && !m_blanking;
    bit commit = 0;
    logic [2:0] req = d_req;
    m_chg = 0;
    if (m_blanking) begin
      if (d_fs) begin
        if (m_frames_left == 1) commit = 1; else m_frames_left--;
      end
      if (!commit) m_pend = req;
    end else if (m_wanted) begin
      if (req == m_cur) m_wanted = 0;
      else begin
        if (d_fs) begin
          if (BF == 0) commit = 1;
          else begin m_blanking = 1; m_wanted = 0; m_frames_left = BF; end
        end
        if (!commit) m_pend = req;
      end
    end else if (req != m_cur) begin
      m_wanted = 1; m_pend = req;
    end
    if (commit) begin
      m_cur = m_pend; m_blanking = 0; m_wanted = 0; m_chg = 1; m_frames_left = 0;
    end
    if (commit) m_tsp_left = 0;
    else if (d_ev && idle) m_tsp_left = HOLD;
    else if (d_fs && m_tsp_left > 0) m_tsp_left--;
    if (d_ev) m_blink = 8;
    else if (d_fs) m_blink = (m_blink + 1) % 256;
    if (d_fs) m_tp = m_s2;
    m_s2 = m_s1; m_s1 = d_tp;
  endtask

  function automatic bit m_tspin();
`ifdef TSPIN_BLINK_EN
    return (m_tsp_left != 0) && (((m_blink >> 3) & 1) == 1);
`else
    return (m_tsp_left != 0);
`endif
  endfunction

  function automatic logic [6:0] obs();
    return {display_screen, blank_active, screen_changed, display_tspin, display_testpattern};
  endfunction

  function automatic logic [6:0] expv();
    return {m_cur, m_blanking, m_chg, m_tspin(), m_tp};
  endfunction

  task automatic tick();
    m_step();
    @(posedge clk); #1;
    d_ev = 0;
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst_l = 0; d_fs = 0; d_ev = 0; d_tp = 0; d_req = START_SCREEN;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL reset_values got %b want %b", obs(), 7'b0);
    end
    @(negedge clk); rst_l = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 10 * FL; c++) begin
      d_fs = (c % FL == 1);
      tick();
      pulses += int'(screen_changed);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL idle_frames cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
    checks++;
    if (pulses != 0 || display_screen !== START_SCREEN || blank_active !== 1'b0) begin
      errors++; $display("FAIL idle_summary got pulses=%0d scr=%0d want 0 0", pulses, display_screen);
    end
  endtask

  task automatic test_screen_switch();
    int pulses = 0, fs_seen = 0, blank_rise = -1, blank_fall = -1;
    d_req = SPRINT_MODE;
    for (int c = 0; c < 6 * FL + 2; c++) begin
      d_fs = (c % FL == 2);
      fs_seen += int'(d_fs);
      tick();
      pulses += int'(screen_changed);
      if (blank_active && blank_rise < 0) blank_rise = fs_seen;
      if (!blank_active && blank_rise >= 0 && blank_fall < 0) blank_fall = fs_seen;
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL switch cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
    checks++;
    if (pulses != 1 || display_screen !== SPRINT_MODE || blank_rise != 1 || blank_fall != 5) begin
      errors++;
      $display("FAIL switch_summary got pulses=%0d scr=%0d rise=%0d fall=%0d want 1 1 1 5",
               pulses, display_screen, blank_rise, blank_fall);
    end
  endtask

  task automatic test_latest_wins();
    int pulses = 0, fs_seen = 0;
    d_req = GAME_OVER;
    for (int c = 0; c < 6 * FL + 2; c++) begin
      d_fs = (c % FL == 2);
      if (d_fs) fs_seen++;
      if (fs_seen == 2 && c % FL == 3) d_req = MP_READY;
      tick();
      pulses += int'(screen_changed);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL latest cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
    checks++;
    if (pulses != 1 || display_screen !== MP_READY) begin
      errors++; $display("FAIL latest_summary got pulses=%0d scr=%0d want 1 2", pulses, display_screen);
    end
  endtask

  task automatic test_withdraw();
    int pulses = 0, blanks = 0;
    d_req = START_SCREEN;
    for (int c = 0; c < 3 * FL + 3; c++) begin
      if (c == 3) d_req = MP_READY;
      d_fs = (c >= 3) && (c % FL == 0);
      tick();
      pulses += int'(screen_changed);
      blanks += int'(blank_active);
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL withdraw cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
    checks++;
    if (pulses != 0 || blanks != 0 || display_screen !== MP_READY) begin
      errors++; $display("FAIL withdraw_summary got pulses=%0d blanks=%0d want 0 0", pulses, blanks);
    end
  endtask

  task automatic test_tspin();
    int fs_after = 0;
    bit bad = 0;
    d_fs = 0; d_ev = 1;
    tick();
    checks++;
    if (obs() !== expv()) begin
      errors++; $display("FAIL tspin_first got %b want %b", obs(), expv());
    end
    for (int c = 0; c < 30 * FL; c++) begin
      d_fs = (c % FL == 1);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL tspin_hold1 cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    // Second event lands on a frame_start.
    for (int c = 0; c < 62 * FL; c++) begin
      d_fs = (c % FL == 1);
      if (c == 1) d_ev = 1;
      tick();
      if (d_fs && c != 1) begin
        fs_after++;
`ifndef TSPIN_BLINK_EN
        if (display_tspin !== (fs_after < HOLD)) bad = 1;
`endif
      end
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL tspin_hold2 cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
`ifndef TSPIN_BLINK_EN
    checks++;
    if (bad) begin
      errors++; $display("FAIL tspin_window got lit-window mismatch want %0d frames", HOLD);
    end
`endif
  endtask

  task automatic test_testpattern();
    bit prev;
    bit prev_fs = 0;
    for (int c = 0; c < 8 * FL; c++) begin
      d_fs = (c % FL == 2);
      if (c == 1 || c == 13 || c == 19) d_tp = ~d_tp;
      prev = display_testpattern;
      tick();
      checks++;
      if (obs() !== expv() || (display_testpattern !== prev && !d_fs)) begin
        errors++; $display("FAIL testpattern cyc %0d got %b want %b", c, obs(), expv());
      end
      prev_fs = d_fs;
    end
    d_fs = 0;
  endtask

  task automatic test_random();
    logic [2:0] pick;
    for (int c = 0; c < 600; c++) begin
      d_fs = ($urandom_range(0, 3) == 0);
      d_ev = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0) d_tp = ~d_tp;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: pick = 3'd0;
          1: pick = 3'd1;
          2: pick = 3'd2;
          default: pick = 3'd7;
        endcase
        d_req = game_screens_t'(pick);
      end
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
  endtask

  task automatic test_reset_mid_blank();
    int guard = 0;
    d_req = (display_screen == SPRINT_MODE) ? MP_GAME : SPRINT_MODE;
    d_ev = 0;
    while (!m_blanking && guard < 40) begin
      d_fs = (guard % FL == 1);
      tick();
      guard++;
    end
    d_fs = 0;
    tick();
    checks++;
    if (blank_active !== 1'b1) begin
      errors++; $display("FAIL enter_blank got %b want 1", blank_active);
    end
    #2 rst_l = 0;
    #1;
    m_reset();
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL async_reset got %b want %b", obs(), 7'b0);
    end
    d_req = START_SCREEN; d_tp = 0;
    @(negedge clk); rst_l = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 3 * FL; c++) begin
      d_fs = (c % FL == 0);
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL post_reset cyc %0d got %b want %b", c, obs(), expv());
      end
    end
    d_fs = 0;
  endtask

  initial begin
    test_reset();
    test_screen_switch();
    test_latest_wins();
    test_withdraw();
    test_tspin();
    test_testpattern();
    test_random();
    test_reset_mid_blank();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
